// File: rtl/memory_stage_if.sv
// Data-memory request/response bus between the memory stage and the data RAM.
interface memory_stage_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/memory_stage.sv
// Memory pipeline stage: holds one instruction, performs its data-memory access with an
// ack timeout, and presents the result to the write stage.
//   state | meaning
//   IDLE  | M holds a non-memory op or a bubble; a new instruction loads every cycle
//   REQ   | access outstanding; upstream stalled, output is a bubble
//   DONE  | access acked; M presented for one cycle while the next instruction loads
module memory_stage #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ex_valid,
    input  logic           ex_RegWrite,
    input  logic           ex_RegStore,
    input  logic           ex_MemRead,
    input  logic           ex_MemWrite,
    input  logic [15:0]    ex_ALUResult,
    input  logic [15:0]    ex_StoreData,
    input  logic [2:0]     ex_rd,
    output logic           stall,
    memory_stage_if.master mem,
    output logic           RegWrite,
    output logic           RegStore,
    output logic [15:0]    ALUResult,
    output logic [15:0]    StoreMem,
    output logic [2:0]     rdWB,
    output logic           mem_err
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

    localparam logic [3:0] LAST_WAIT = 4'(ACK_TIMEOUT - 1);

    state_t      state, stateNext;
    logic        loadM, timeout, inReq, bubble;
    logic        mValid, mRegWrite, mRegStore, mMemRead, mMemWrite;
    logic [15:0] mAluResult, mStoreData, rdataQ;
    logic [2:0]  mRd;
    logic [3:0]  waitCnt;
    logic        memErr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        loadM     = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE, DONE: begin
                loadM     = 1'b1;
                stateNext = (ex_valid && (ex_MemRead || ex_MemWrite)) ? REQ : IDLE;
            end
            REQ: begin
                // An ack in the final wait cycle still wins over the timeout.
                if (mem.ack) begin
                    stateNext = DONE;
                end else if (waitCnt == LAST_WAIT) begin
                    stateNext = IDLE;
                    timeout   = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign inReq = (state == REQ);
    assign stall = inReq;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mValid     <= 1'b0;
            mRegWrite  <= 1'b0;
            mRegStore  <= 1'b0;
            mMemRead   <= 1'b0;
            mMemWrite  <= 1'b0;
            mAluResult <= '0;
            mStoreData <= '0;
            mRd        <= '0;
            waitCnt    <= '0;
            rdataQ     <= '0;
            memErr     <= 1'b0;
        end else begin
            if (loadM) begin
                mValid     <= ex_valid;
                mRegWrite  <= ex_RegWrite;
                mRegStore  <= ex_RegStore;
                mMemRead   <= ex_MemRead;
                mMemWrite  <= ex_MemWrite;
                mAluResult <= ex_ALUResult;
                mStoreData <= ex_StoreData;
                mRd        <= ex_rd;
                waitCnt    <= '0;
            end else begin
                if (inReq && !mem.ack) waitCnt <= waitCnt + 4'd1;
                // A timed-out access is squashed so it never reaches writeback.
                if (timeout) mValid <= 1'b0;
            end
            if (inReq && mem.ack) rdataQ <= mem.rdata;
            if (timeout)          memErr <= 1'b1;
        end
    end

    assign bubble = !mValid || inReq;

    always_comb begin
        RegWrite  = 1'b0;
        RegStore  = 1'b0;
        ALUResult = '0;
        StoreMem  = '0;
        rdWB      = '0;
        if (!bubble) begin
            RegWrite  = mRegWrite;
            RegStore  = mRegStore;
            ALUResult = mAluResult;
            rdWB      = mRd;
            // Write wins when both read and write are set, so only pure loads return data.
            if (state == DONE && mMemRead && !mMemWrite) StoreMem = rdataQ;
        end
    end

    assign mem.req   = inReq;
    assign mem.we    = inReq & mMemWrite;
    assign mem.addr  = inReq ? mAluResult : '0;
    assign mem.wdata = inReq ? mStoreData : '0;
    assign mem_err   = memErr;
endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15, SHALL set the maximum number of REQ cycles to wait for mem_ack (range 2..15).
REQ-002 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low; reset=0 SHALL clear all state immediately, independent of clk.
REQ-004 ex_valid  in  1  execute stage presents an instruction.
REQ-005 ex_RegWrite, ex_RegStore, ex_MemRead, ex_MemWrite  in  1 each  control bits from execute.
REQ-006 ex_ALUResult  in  16  ALU result, also the memory address; ex_StoreData  in  16  write data; ex_rd  in  3  destination register.
REQ-007 stall  out  1  high: upstream SHALL hold all ex_* inputs stable.
REQ-008 mem_req  out  1; mem_we  out  1; mem_addr  out  16; mem_wdata  out  16  data-memory request.
REQ-009 mem_rdata  in  16; mem_ack  in  1  memory response, sampled only in REQ.
REQ-010 RegWrite, RegStore  out  1 each; ALUResult, StoreMem  out  16 each; rdWB  out  3  feed to the write stage.
REQ-011 mem_err  out  1  sticky access-timeout flag.

Function
REQ-012 The stage SHALL hold one instruction register M (valid, control bits, ALUResult, StoreData, rd), loaded from ex_* on every edge where stall=0; ex_valid=0 SHALL load valid=0.
REQ-013 The FSM SHALL have states IDLE, REQ, DONE; at a load edge the next state SHALL be REQ if ex_valid and (ex_MemRead or ex_MemWrite), else IDLE.
REQ-014 REQ: mem_req=1, stall=1, mem_addr=M.ALUResult, mem_wdata=M.StoreData, mem_we=M.MemWrite; the address and data SHALL stay stable until ack.
REQ-015 mem_ack=1 in REQ SHALL latch mem_rdata into rdata_q and move to DONE at the next edge.
REQ-016 With MemRead and MemWrite both set, the write SHALL take priority: mem_we=1, StoreMem=0.
REQ-017 IDLE and DONE SHALL drive stall=0 and mem_req=0.
REQ-018 Outputs SHALL be driven from M: RegWrite=M.RegWrite, RegStore=M.RegStore, ALUResult=M.ALUResult, rdWB=M.rd, StoreMem=rdata_q in DONE for reads, else 0.
REQ-019 When M.valid=0 or the state is REQ, the stage SHALL output a bubble: RegWrite=0, RegStore=0, ALUResult=0, StoreMem=0, rdWB=0.
REQ-020 Latency: a non-memory op SHALL be presented for exactly 1 cycle; a memory op SHALL be presented for 1 cycle in DONE; with ack in the first REQ cycle a load SHALL occupy 2 cycles.
REQ-021 A 4-bit wait counter SHALL clear on entry to REQ and increment in each REQ cycle without ack.
REQ-022 When the counter reaches ACK_TIMEOUT-1 without ack, the next edge SHALL:
  - set mem_err=1;
  - clear M.valid;
  - enter IDLE, so the instruction is squashed and never written back.
REQ-023 mem_err SHALL stay set until reset.
REQ-024 mem_ack outside REQ SHALL be ignored.
REQ-025 Ack on the same cycle as the timeout count SHALL count as success, not timeout.
REQ-026 Back-to-back memory ops: DONE SHALL load the next instruction and go directly to REQ; there SHALL be no idle cycle between them.

Reset
REQ-027 During reset=0, M.valid, state (IDLE), counter, rdata_q and mem_err SHALL be 0, so all outputs are 0 and mem_req=0 at once.
REQ-028 Reset asserted mid-REQ SHALL abort the access, with no writeback after release.
REQ-029 After reset deassertion, the first rising edge SHALL load ex_* normally.

Verification
REQ-030 ALU op, ex_ALUResult=0x1234, rd=5, RegWrite=1 -> next cycle ALUResult=0x1234, rdWB=5, RegWrite=1, stall=0, mem_req=0.
REQ-031 Load, addr 0x0040, ack after 3 REQ cycles with rdata=0xBEEF -> 3 cycles mem_req=1, stall=1, bubble out; then 1 DONE cycle with StoreMem=0xBEEF, RegWrite=1.
REQ-032 Store, addr 0x0010, data 0x00FF, immediate ack -> mem_we=1, mem_wdata=0x00FF for 1 cycle; DONE outputs RegWrite=0, StoreMem=0.
REQ-033 Load with no ack, ACK_TIMEOUT=4 -> mem_req high for 4 cycles; then mem_err=1, bubble out; the next instruction is accepted.
REQ-034 Two consecutive loads, both acked immediately -> REQ, DONE, REQ, DONE pattern; each rdata is presented once.
REQ-035 reset=0 asserted in the second REQ cycle -> mem_req=0 and outputs 0 the same cycle; no writeback after release.
